dly_ld_sequencer: RTL
=====================

// Module: dly_ld_sequencer
// PURPOSE
// Upstream control stage for the memory PHY I/O delay cells (DQ/DQS IDELAY/ODELAY in dq_single/dqs_single).
// Accepts a stream of (cell address, 8-bit delay) writes and stages each value into its cell with a one-hot set strobe.
// On the last write of a batch it issues a single broadcast ld pulse so all staged values take effect together.
// Holds off until the IDELAYCTRL ready is asserted, and aborts the batch if ready drops.
// PARAMETERS
// NUM_DLY    20  number of addressable delay cells (odelay and idelay each count as one cell)
// ADDR_W     5   width of req_addr; must satisfy 2**ADDR_W >= NUM_DLY
// SET_TO_LD  2   idle cycles between the last set strobe and the ld pulse (1..15)
// LD_HOLD    3   idle cycles after ld before done pulses and req_ready returns (1..15)
// PORTS
// clk_div    in   1        only clock (half-rate PHY clock); all logic on its rising edge
// rst        in   1        synchronous, active-high reset
// dly_ready  in   1        IDELAYCTRL ready (rdy); treated as synchronous to clk_div
// req_valid  in   1        write request valid
// req_ready  out  1        write request accepted when req_valid & req_ready
// req_addr   in   ADDR_W   target cell index
// req_data   in   8        delay value ([7:3] tap, [2:0] fine)
// req_last   in   1        this write closes the batch; ld follows
// dly_data   out  8        shared delay bus to all cells
// set_dly    out  NUM_DLY  one-hot set strobe; cell i loads dly_data when set_dly[i]=1
// ld_dly     out  1        broadcast ld strobe; all cells apply their staged values
// busy       out  1        high in every state except IDLE
// done       out  1        1-cycle pulse when a batch has completed
// err_addr   out  1        1-cycle pulse: accepted request had req_addr >= NUM_DLY
// lost_rdy   out  1        1-cycle pulse: dly_ready fell outside WAIT_RDY and the batch was aborted
// BEHAVIOUR
// - Reset values: state=WAIT_RDY; dly_data=0; set_dly=0; ld_dly=0; req_ready=0; busy=1; done, err_addr, lost_rdy=0; counter=0.
// - All outputs are registered, and req_ready is a registered state decode (=1 only in IDLE).
// - States and transitions:
//   - WAIT_RDY: go to IDLE on the first cycle dly_ready=1.
//   - IDLE: on accept (req_valid & req_ready), the next cycle has dly_data=req_data and set_dly=1<<req_addr, both for exactly 1 cycle (latency 1).
//     - Back-to-back accepts give set pulses on consecutive cycles, with dly_data updated each cycle.
//     - Accept with req_last=1 goes to GAP; req_ready=0 from the next cycle.
//   - GAP: count SET_TO_LD cycles after the last set cycle, then go to LD.
//   - LD: ld_dly=1 for exactly 1 cycle, then go to HOLD.
//   - HOLD: count LD_HOLD cycles, then pulse done in the same cycle busy falls and req_ready rises; return to IDLE.
// - Bad address: req_addr >= NUM_DLY is still accepted. set_dly stays 0 and err_addr pulses in the cycle the set would have occurred.
//   - If that request is last, ld still issues.
// - dly_data holds its last value when no set is active; it is never cleared except by reset.
// - Abort: dly_ready=0 in any state other than WAIT_RDY forces WAIT_RDY on the next cycle.
//   - In that cycle: set_dly=0, ld_dly=0 (no pending ld is issued), req_ready=0, and lost_rdy pulses.
//   - A request presented in the same cycle that dly_ready falls is accepted only if req_ready was already 1; its set strobe is suppressed.
// - rst is asserted mid-batch: the reset values apply next cycle and no ld is issued.
// - Counter is 4 bits. It loads the parameter value on state entry and decrements to 0; no wrap-around.
// STRUCTURE
// - Single flat module; state codes are module-local localparams.
// - Delay word width (8) and the IODELAY group name belong in the shared PHY parameter include, used by both this block and dq_single/dqs_single.
// - No sub-module: the one-hot decode is a single expression.
// TESTING
// 1 Reset, dly_ready=0 for 10 cycles then 1 -> req_ready rises on the 2nd cycle after dly_ready=1; all strobes 0 throughout.
// 2 Single write: addr=3, data=8'h5A, last=1 -> next cycle set_dly=20'h00008, dly_data=8'h5A;
//   ld_dly 3 cycles after the set (SET_TO_LD=2); done 4 cycles after ld (LD_HOLD=3).
// 3 Three back-to-back writes: addr 0/7/19, data 8'h11/8'h22/8'h33, last on the 3rd -> three consecutive one-hot sets with matching data, exactly one ld.
// 4 addr=25, last=1 -> set_dly stays 0, err_addr pulses once, ld_dly still pulses, done pulses.
// 5 dly_ready driven low during GAP -> no ld_dly, lost_rdy=1 for one cycle, state WAIT_RDY;
//   restore ready and write addr=1 -> normal set and ld.
// 6 rst pulsed for 1 cycle during HOLD -> all outputs at reset values next cycle; no done pulse.

Source files
------------

// File: rtl/dly_ld_sequencer_pkg.sv
// Shared PHY delay-path definitions: delay word width and counter sizing used
// by the ld sequencer and the dq/dqs delay cells.
package dly_ld_sequencer_pkg;

    localparam int DLY_W = 8;
    localparam int CNT_W = 4;

    // Gap lengths outside 1..15 cannot be represented by the 4-bit counter.
    function automatic logic [CNT_W-1:0] cnt_init(input int v);
        if (v < 1)  return CNT_W'(1);
        if (v > 15) return CNT_W'(15);
        return CNT_W'(v);
    endfunction

endpackage

// File: rtl/dly_ld_sequencer.sv
// Stages (address, delay) writes into the PHY I/O delay cells with one-hot set
// strobes and closes each batch with a single broadcast ld pulse.
module dly_ld_sequencer
    import dly_ld_sequencer_pkg::*;
#(
    parameter int NUM_DLY   = 20,
    parameter int ADDR_W    = 5,
    parameter int SET_TO_LD = 2,
    parameter int LD_HOLD   = 3
) (
    input  logic               clk_div,
    input  logic               rst,
    input  logic               dly_ready,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [ADDR_W-1:0]  req_addr,
    input  logic [DLY_W-1:0]   req_data,
    input  logic               req_last,
    output logic [DLY_W-1:0]   dly_data,
    output logic [NUM_DLY-1:0] set_dly,
    output logic               ld_dly,
    output logic               busy,
    output logic               done,
    output logic               err_addr,
    output logic               lost_rdy
);

    typedef enum logic [2:0] {
        S_WAIT_RDY,
        S_IDLE,
        S_GAP,
        S_LD,
        S_HOLD
    } state_t;

    localparam logic [ADDR_W:0]    NUM_DLY_A = (ADDR_W + 1)'(NUM_DLY);
    localparam logic [NUM_DLY-1:0] ONE_BIT   = {{(NUM_DLY - 1){1'b0}}, 1'b1};

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             addr_ok;

    assign accept  = req_valid & req_ready;
    assign addr_ok = ({1'b0, req_addr} < NUM_DLY_A);

    always_ff @(posedge clk_div) begin
        if (rst) begin
            state     <= S_WAIT_RDY;
            cnt       <= '0;
            dly_data  <= '0;
            set_dly   <= '0;
            ld_dly    <= 1'b0;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b0;
            err_addr  <= 1'b0;
            lost_rdy  <= 1'b0;
        end else begin
            set_dly  <= '0;
            ld_dly   <= 1'b0;
            done     <= 1'b0;
            err_addr <= 1'b0;
            lost_rdy <= 1'b0;

            // An accepted write always lands on the bus, even if the batch aborts now.
            if (accept) begin
                dly_data <= req_data;
                err_addr <= ~addr_ok;
            end

            if (state != S_WAIT_RDY && !dly_ready) begin
                state     <= S_WAIT_RDY;
                cnt       <= '0;
                req_ready <= 1'b0;
                busy      <= 1'b1;
                lost_rdy  <= 1'b1;
            end else begin
                case (state)
                    S_WAIT_RDY: begin
                        if (dly_ready) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    S_IDLE: begin
                        req_ready <= 1'b1;
                        if (accept) begin
                            set_dly <= addr_ok ? (ONE_BIT << req_addr) : '0;
                            if (req_last) begin
                                state     <= S_GAP;
                                cnt       <= cnt_init(SET_TO_LD);
                                req_ready <= 1'b0;
                                busy      <= 1'b1;
                            end
                        end
                    end
                    // The set cycle itself is the first GAP cycle, then SET_TO_LD idle cycles.
                    S_GAP: begin
                        if (cnt == '0) begin
                            state  <= S_LD;
                            ld_dly <= 1'b1;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    S_LD: begin
                        state <= S_HOLD;
                        cnt   <= cnt_init(LD_HOLD);
                    end
                    // Exactly LD_HOLD idle cycles follow ld; done lands on the next one.
                    S_HOLD: begin
                        if (cnt <= CNT_W'(1)) begin
                            state     <= S_IDLE;
                            cnt       <= '0;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            req_ready <= 1'b1;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    default: begin
                        state     <= S_WAIT_RDY;
                        cnt       <= '0;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
